// File: rtl/image_mem_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : image_mem_scheduler                                              |
// | Purpose : Shares the image ROM read port between VGA, decrypter fetch and  |
// |           a copy-back engine that fills the decryption RAM.                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module image_mem_scheduler #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 8,
   parameter int IMG_WORDS = 19200,
   parameter int MAX_WAIT  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              vga_miss,
   input  logic              dec_req,
   input  logic [ADDR_W-1:0] dec_addr,
   output logic              dec_gnt,
   output logic              dec_rvalid,
   output logic [DATA_W-1:0] dec_rdata,
   input  logic              dec_done,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              copy_busy,
   output logic              copy_done
);

   localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [ADDR_W-1:0]   c_LAST     = ADDR_W'(IMG_WORDS - 1);
   localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_COPY     = 2'd1,
      S_FINISHED = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_DEC  = 2'd2,
      OWN_COPY = 2'd3
   } owner_t;

   state_t              r_state, w_state_nxt;
   owner_t              w_owner, r_tag1, r_tag2;
   logic [ADDR_W-1:0]   r_mem_addr, w_issue_addr, r_addr2;
   logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
   logic                r_copy_issued, w_copy_issued_nxt;
   logic [c_WAIT_W-1:0] r_wait, w_wait_nxt;
   logic                r_dec_done_q, r_miss;
   logic                w_dec_rise, w_miss_set, w_last_write;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_RUN;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_owner           = OWN_NONE;
      w_issue_addr      = r_mem_addr;
      w_ptr_nxt         = r_ptr;
      w_copy_issued_nxt = r_copy_issued;
      w_miss_set        = 1'b0;
      w_dec_rise        = dec_done & ~r_dec_done_q;
      w_last_write      = (r_tag2 == OWN_COPY) && (r_addr2 == c_LAST);

      case (r_state)
         S_RUN: begin
            // A dec_done edge claims the slot from the decrypter, never from VGA.
            if (dec_req && !w_dec_rise && r_wait == c_MAX_WAIT) begin
               w_owner      = OWN_DEC;
               w_issue_addr = dec_addr;
               w_miss_set   = vga_req;
            end else if (vga_req) begin
               w_owner      = OWN_VGA;
               w_issue_addr = vga_addr;
            end else if (dec_req && !w_dec_rise) begin
               w_owner      = OWN_DEC;
               w_issue_addr = dec_addr;
            end
            if (w_dec_rise) begin
               w_state_nxt       = S_COPY;
               w_ptr_nxt         = '0;
               w_copy_issued_nxt = 1'b0;
            end
         end
         S_COPY: begin
            if (vga_req) begin
               w_owner      = OWN_VGA;
               w_issue_addr = vga_addr;
            end else if (!r_copy_issued) begin
               w_owner      = OWN_COPY;
               w_issue_addr = r_ptr;
               if (r_ptr == c_LAST) w_copy_issued_nxt = 1'b1;
               else                 w_ptr_nxt         = r_ptr + ADDR_W'(1);
            end
            if (w_last_write) w_state_nxt = S_FINISHED;
         end
         S_FINISHED: begin
            if (vga_req) begin
               w_owner      = OWN_VGA;
               w_issue_addr = vga_addr;
            end
            if (w_dec_rise) begin
               w_state_nxt       = S_COPY;
               w_ptr_nxt         = '0;
               w_copy_issued_nxt = 1'b0;
            end
         end
         default: w_state_nxt = S_RUN;
      endcase

      if (!dec_req || w_owner == OWN_DEC) w_wait_nxt = '0;
      else if (r_wait != c_MAX_WAIT)      w_wait_nxt = r_wait + c_WAIT_W'(1);
      else                                w_wait_nxt = r_wait;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait        <= '0;
         r_ptr         <= '0;
         r_copy_issued <= 1'b0;
         r_dec_done_q  <= 1'b0;
         r_miss        <= 1'b0;
         r_mem_addr    <= '0;
         r_tag1        <= OWN_NONE;
         r_tag2        <= OWN_NONE;
         r_addr2       <= '0;
      end else begin
         r_wait        <= w_wait_nxt;
         r_ptr         <= w_ptr_nxt;
         r_copy_issued <= w_copy_issued_nxt;
         r_dec_done_q  <= dec_done;
         r_miss        <= r_miss | w_miss_set;
         r_mem_addr    <= w_issue_addr;
         r_tag1        <= w_owner;
         r_tag2        <= r_tag1;
         r_addr2       <= r_mem_addr;
      end
   end

   // Returned data is steered by the tag that travelled alongside the ROM access.
   assign mem_addr   = r_mem_addr;
   assign vga_miss   = r_miss;
   assign dec_gnt    = rst && (w_owner == OWN_DEC);
   assign vga_rvalid = (r_tag2 == OWN_VGA);
   assign vga_rdata  = vga_rvalid ? mem_dout : '0;
   assign dec_rvalid = (r_tag2 == OWN_DEC);
   assign dec_rdata  = dec_rvalid ? mem_dout : '0;
   assign wr_en      = (r_tag2 == OWN_COPY) && (r_state == S_COPY);
   assign wr_addr    = wr_en ? r_addr2 : '0;
   assign wr_data    = wr_en ? mem_dout : '0;
   assign copy_busy  = (r_state == S_COPY);
   assign copy_done  = (r_state == S_FINISHED);

endmodule
`default_nettype wire

// File: tb/tb_image_mem_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_image_mem_scheduler                                           |
// | Purpose : Randomised self-checking bench for image_mem_scheduler.          |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_image_mem_scheduler;

   localparam int AW = 15, DW = 8, IMG = 16, MAXW = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          vga_req = 1'b0, dec_req = 1'b0, dec_done = 1'b0;
   logic [AW-1:0] vga_addr = '0, dec_addr = '0;
   logic          vga_rvalid, vga_miss, dec_gnt, dec_rvalid, wr_en, copy_busy, copy_done;
   logic [DW-1:0] vga_rdata, dec_rdata, wr_data;
   logic [DW-1:0] mem_dout = '0;
   logic [AW-1:0] mem_addr, wr_addr;

   int n_tests = 0, n_fail = 0;

   image_mem_scheduler #(.ADDR_W(AW), .DATA_W(DW), .IMG_WORDS(IMG), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst),
      .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid),
      .vga_rdata(vga_rdata), .vga_miss(vga_miss),
      .dec_req(dec_req), .dec_addr(dec_addr), .dec_gnt(dec_gnt),
      .dec_rvalid(dec_rvalid), .dec_rdata(dec_rdata), .dec_done(dec_done),
      .mem_addr(mem_addr), .mem_dout(mem_dout),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .copy_busy(copy_busy), .copy_done(copy_done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      return a[7:0] ^ {a[14:8], 1'b1} ^ 8'hA5;
   endfunction

   // Image ROM with one cycle of synchronous read latency
   always @(posedge clk) mem_dout <= rom_f(mem_addr);

   // Reference model: modes 0=arbitrate, 1=copying, 2=copy finished
   int            cyc = 0;
   int            m_mode, m_mode_next, m_wait, m_ptr;
   bit            m_dd_prev, m_miss, m_miss_next, m_gnt;
   logic [AW-1:0] m_mem_addr, m_mem_addr_next, m_ret_addr_now;
   int            m_own_now;
   int            ret_own [4];
   logic [AW-1:0] ret_addr [4];

   task automatic model_reset();
      m_mode = 0; m_mode_next = 0; m_wait = 0; m_ptr = 0;
      m_dd_prev = 0; m_miss = 0; m_miss_next = 0; m_gnt = 0;
      m_mem_addr = '0; m_mem_addr_next = '0; m_own_now = 0; m_ret_addr_now = '0;
      for (int i = 0; i < 4; i++) begin ret_own[i] = 0; ret_addr[i] = '0; end
   endtask

   task automatic do_reset();
      rst = 1'b0; vga_req = 0; dec_req = 0; dec_done = 0; vga_addr = '0; dec_addr = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Drives one cycle of stimulus, predicts it, and returns at the falling edge.
   task automatic step(input logic vr, input logic [AW-1:0] va, input logic dr,
                       input logic [AW-1:0] da, input logic dd);
      int own; logic [AW-1:0] a; bit rise;
      @(posedge clk); #1;
      cyc++;
      m_mode = m_mode_next; m_miss = m_miss_next; m_mem_addr = m_mem_addr_next;
      vga_req = vr; vga_addr = va; dec_req = dr; dec_addr = da; dec_done = dd;
      rise = dd && !m_dd_prev; m_dd_prev = dd;
      own = 0; a = '0;
      m_own_now = ret_own[cyc % 4]; m_ret_addr_now = ret_addr[cyc % 4];
      case (m_mode)
         0: begin
            if (dr && !rise && (m_wait == MAXW || !vr)) begin
               own = 2; a = da;
               if (vr) m_miss_next = 1;
            end else if (vr) begin own = 1; a = va; end
            if (rise) begin m_mode_next = 1; m_ptr = 0; end
         end
         1: begin
            if (vr) begin own = 1; a = va; end
            else if (m_ptr < IMG) begin own = 3; a = AW'(m_ptr); m_ptr++; end
            if (m_own_now == 3 && m_ret_addr_now == AW'(IMG - 1)) m_mode_next = 2;
         end
         default: begin
            if (vr) begin own = 1; a = va; end
            if (rise) begin m_mode_next = 1; m_ptr = 0; end
         end
      endcase
      m_gnt = (own == 2);
      m_wait = (!dr || own == 2) ? 0 : ((m_wait < MAXW) ? m_wait + 1 : MAXW);
      ret_own[(cyc + 2) % 4] = own; ret_addr[(cyc + 2) % 4] = a;
      if (own != 0) m_mem_addr_next = a;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      @(negedge clk);
      n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      n_tests++; if ({vga_rvalid, dec_rvalid, dec_gnt, wr_en} !== 4'b0) begin n_fail++; $display("FAIL reset_strobes got %b want 0000", {vga_rvalid, dec_rvalid, dec_gnt, wr_en}); end
      n_tests++; if ({copy_busy, copy_done, vga_miss} !== 3'b0) begin n_fail++; $display("FAIL reset_status got %b want 000", {copy_busy, copy_done, vga_miss}); end
      rst = 1'b1;
   endtask

   task automatic test_arbitration();
      logic vr, dr; logic [AW-1:0] va, da;
      step(1, 15'h0010, 1, 15'h0200, 0);
      n_tests++; if (dec_gnt !== 1'b0) begin n_fail++; $display("FAIL arb_no_gnt got %b want 0", dec_gnt); end
      step(0, '0, 0, '0, 0);
      n_tests++; if (mem_addr !== 15'h0010) begin n_fail++; $display("FAIL arb_mem_addr got %h want 0010", mem_addr); end
      step(0, '0, 0, '0, 0);
      n_tests++; if (vga_rvalid !== 1'b1 || vga_rdata !== rom_f(15'h0010)) begin n_fail++; $display("FAIL arb_vga_data got %b/%h want 1/%h", vga_rvalid, vga_rdata, rom_f(15'h0010)); end
      dr = 0; da = '0;
      for (int i = 0; i < 60; i++) begin
         vr = 1'($urandom_range(0, 1)); va = AW'($urandom);
         if (!dr) begin dr = 1'($urandom_range(0, 1)); da = AW'($urandom); end
         step(vr, va, dr, da, 0);
         n_tests++; if (dec_gnt !== m_gnt) begin n_fail++; $display("FAIL arb_gnt cyc %0d got %b want %b", cyc, dec_gnt, m_gnt); end
         n_tests++; if (mem_addr !== m_mem_addr) begin n_fail++; $display("FAIL arb_addr cyc %0d got %h want %h", cyc, mem_addr, m_mem_addr); end
         n_tests++; if (vga_rvalid !== (m_own_now == 1) || (m_own_now == 1 && vga_rdata !== rom_f(m_ret_addr_now))) begin
            n_fail++; $display("FAIL arb_vga cyc %0d got %b/%h want %b/%h", cyc, vga_rvalid, vga_rdata, m_own_now == 1, rom_f(m_ret_addr_now)); end
         n_tests++; if (dec_rvalid !== (m_own_now == 2) || (m_own_now == 2 && dec_rdata !== rom_f(m_ret_addr_now))) begin
            n_fail++; $display("FAIL arb_dec cyc %0d got %b/%h want %b/%h", cyc, dec_rvalid, dec_rdata, m_own_now == 2, rom_f(m_ret_addr_now)); end
         if (m_gnt) dr = 0;
      end
   endtask

   task automatic test_blanking();
      logic [AW-1:0] da;
      step(0, '0, 0, '0, 0);
      for (int i = 0; i < 4; i++) begin
         da = AW'($urandom);
         step(0, '0, 1, da, 0);
         n_tests++; if (dec_gnt !== 1'b1) begin n_fail++; $display("FAIL blank_gnt got %b want 1", dec_gnt); end
         step(0, '0, 0, '0, 0);
         step(0, '0, 0, '0, 0);
         n_tests++; if (dec_rvalid !== 1'b1 || dec_rdata !== rom_f(da)) begin n_fail++; $display("FAIL blank_data got %b/%h want 1/%h", dec_rvalid, dec_rdata, rom_f(da)); end
      end
      step(1, AW'($urandom), 1, AW'($urandom), 0);
      n_tests++; if (dec_gnt !== 1'b0) begin n_fail++; $display("FAIL blank_wait_clear got %b want 0", dec_gnt); end
      step(0, '0, 0, '0, 0);
   endtask

   task automatic test_starvation();
      logic [AW-1:0] da; int g1, g2, ng;
      step(0, '0, 0, '0, 0);
      da = AW'($urandom); g1 = -1; g2 = -1; ng = 0;
      for (int i = 1; i <= 135; i++) begin
         step(1, AW'($urandom), 1, da, 0);
         n_tests++; if (dec_gnt !== m_gnt) begin n_fail++; $display("FAIL starve_gnt step %0d got %b want %b", i, dec_gnt, m_gnt); end
         if (dec_gnt === 1'b1) begin ng++; if (ng == 1) g1 = i; else if (ng == 2) g2 = i; end
         if (m_own_now == 2) begin
            n_tests++; if (dec_rvalid !== 1'b1 || dec_rdata !== rom_f(m_ret_addr_now)) begin n_fail++; $display("FAIL starve_data got %b/%h want 1/%h", dec_rvalid, dec_rdata, rom_f(m_ret_addr_now)); end
         end
         if (m_gnt) da = AW'($urandom);
      end
      n_tests++; if (g1 != 65) begin n_fail++; $display("FAIL starve_first_gnt got %0d want 65", g1); end
      n_tests++; if (g2 != 130) begin n_fail++; $display("FAIL starve_second_gnt got %0d want 130", g2); end
      n_tests++; if (vga_miss !== 1'b1) begin n_fail++; $display("FAIL starve_miss got %b want 1", vga_miss); end
      step(0, '0, 0, '0, 0);
   endtask

   // Runs one copy-back from a dec_done rise; toggle selects VGA interleave.
   task automatic run_copy(input bit toggle, output int dur, output int n_wr);
      logic vr;
      dur = -1; n_wr = 0;
      step(0, '0, 0, '0, 0);
      step(0, '0, 0, '0, 1);
      for (int i = 1; i <= 80 && dur < 0; i++) begin
         vr = toggle ? 1'(i % 2) : 1'b0;
         step(vr, AW'($urandom), 0, '0, 1);
         n_tests++; if (wr_en !== (m_own_now == 3)) begin n_fail++; $display("FAIL copy_wr_en step %0d got %b want %b", i, wr_en, m_own_now == 3); end
         if (m_own_now == 3) begin
            n_tests++; if (wr_addr !== AW'(n_wr) || wr_data !== rom_f(AW'(n_wr))) begin
               n_fail++; $display("FAIL copy_write step %0d got %h/%h want %h/%h", i, wr_addr, wr_data, AW'(n_wr), rom_f(AW'(n_wr))); end
            n_wr++;
         end
         if (m_own_now == 1) begin
            n_tests++; if (vga_rvalid !== 1'b1 || vga_rdata !== rom_f(m_ret_addr_now)) begin n_fail++; $display("FAIL copy_vga got %b/%h want 1/%h", vga_rvalid, vga_rdata, rom_f(m_ret_addr_now)); end
         end
         n_tests++; if (copy_busy !== (m_mode == 1)) begin n_fail++; $display("FAIL copy_busy step %0d got %b want %b", i, copy_busy, m_mode == 1); end
         if (copy_done === 1'b1) dur = i;
      end
      n_tests++; if (copy_busy !== 1'b0 || copy_done !== 1'b1) begin n_fail++; $display("FAIL copy_end got %b/%b want 0/1", copy_busy, copy_done); end
      for (int i = 0; i < 3; i++) begin
         step(0, '0, 0, '0, 1);
         n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL copy_stray_wr got %b want 0", wr_en); end
      end
   endtask

   task automatic test_copy_idle();
      int dur, nw;
      run_copy(1'b0, dur, nw);
      n_tests++; if (nw != IMG) begin n_fail++; $display("FAIL copy_idle_count got %0d want %0d", nw, IMG); end
      n_tests++; if (dur != IMG + 3) begin n_fail++; $display("FAIL copy_idle_dur got %0d want %0d", dur, IMG + 3); end
   endtask

   task automatic test_copy_interleave();
      int dur, nw;
      run_copy(1'b1, dur, nw);
      n_tests++; if (nw != IMG) begin n_fail++; $display("FAIL copy_il_count got %0d want %0d", nw, IMG); end
      n_tests++; if (dur != 2 * IMG + 3) begin n_fail++; $display("FAIL copy_il_dur got %0d want %0d", dur, 2 * IMG + 3); end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] d1, d2;
      do_reset();
      d1 = AW'($urandom); d2 = AW'($urandom);
      step(0, '0, 1, d1, 0);
      n_tests++; if (dec_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_first_gnt got %b want 1", dec_gnt); end
      step(0, '0, 1, d2, 1);
      n_tests++; if (dec_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_rise_gnt got %b want 0", dec_gnt); end
      step(0, '0, 1, d2, 1);
      n_tests++; if (dec_rvalid !== 1'b1 || dec_rdata !== rom_f(d1)) begin n_fail++; $display("FAIL b2b_inflight got %b/%h want 1/%h", dec_rvalid, dec_rdata, rom_f(d1)); end
      n_tests++; if (copy_busy !== 1'b1 || dec_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_copy got %b/%b want 1/0", copy_busy, dec_gnt); end
   endtask

   task automatic test_reset_mid_copy();
      for (int i = 0; i < 30 && m_ptr != 7; i++) step(0, '0, 0, '0, 1);
      n_tests++; if (m_ptr != 7 || copy_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_reach ptr %0d busy %b want 7/1", m_ptr, copy_busy); end
      #2; rst = 1'b0; dec_done = 1'b0; #1;
      n_tests++; if (mem_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin n_fail++; $display("FAIL midrst_buses got %h/%h/%h want 0", mem_addr, wr_addr, wr_data); end
      n_tests++; if ({wr_en, copy_busy, copy_done, vga_rvalid, dec_rvalid, dec_gnt, vga_miss} !== 7'b0) begin
         n_fail++; $display("FAIL midrst_flags got %b want 0000000", {wr_en, copy_busy, copy_done, vga_rvalid, dec_rvalid, dec_gnt, vga_miss}); end
      model_reset();
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(0, '0, 0, '0, 0);
         n_tests++; if (wr_en !== 1'b0 || copy_busy !== 1'b0 || copy_done !== 1'b0) begin n_fail++; $display("FAIL midrst_after got %b%b%b want 000", wr_en, copy_busy, copy_done); end
      end
      step(0, '0, 1, 15'h0123, 0);
      n_tests++; if (dec_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_run got %b want 1", dec_gnt); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_arbitration();
      test_blanking();
      test_starvation();
      test_copy_idle();
      test_copy_interleave();
      test_back_to_back();
      test_reset_mid_copy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
